axis_governor_ctl: RTL

Debug controller that sequences one stream governor on the same clock. It accepts 32-bit commands on an AXI Stream command port and drives the governor's `pause`, `drop` and `log_en` controls from registers. It monitors the governor's input handshake so it can free-run, single-step N flits, or run until a TDEST breakpoint, then re-pause. It sits between a host command channel and the governor's control inputs.

---
 rtl/axis_governor_ctl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/axis_governor_ctl.sv
// ---------------------------------------------------------------------------
// axis_governor_ctl
//
// Debug controller for one stream governor on the same clock. Host commands
// arrive on a 32-bit AXI Stream port and steer the governor's pause / drop /
// log_en controls. The governor's input handshake is monitored so the block
// can free-run, single-step N flits, or run until a TDEST breakpoint, and
// then re-pause the governor.
//
// Ports
//   clk, rst          : sole clock (rising edge), synchronous active-high reset
//   cmd_TDATA/TVALID  : command word [31:28] opcode, [27:0] argument
//   cmd_TREADY        : command ready, high whenever rst is low
//   mon_TVALID/TREADY : governor input handshake (observed only)
//   mon_TDEST         : governor input TDEST (observed only)
//   pause/drop/log_en : registered governor controls
//   state             : 0 PAUSED, 1 RUN, 2 STEP, 3 RUN_BP
//   flit_count        : monitored handshakes since reset, wraps at 2^32
//   bp_hit            : one-cycle pulse when a breakpoint stops RUN_BP
// ---------------------------------------------------------------------------
module axis_governor_ctl #(
  parameter int DEST_WIDTH = 16  // must not exceed 28 (argument field width)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cmd_TDATA,
  input  logic                  cmd_TVALID,
  output logic                  cmd_TREADY,
  input  logic                  mon_TVALID,
  input  logic                  mon_TREADY,
  input  logic [DEST_WIDTH-1:0] mon_TDEST,
  output logic                  pause,
  output logic                  drop,
  output logic                  log_en,
  output logic [1:0]            state,
  output logic [31:0]           flit_count,
  output logic                  bp_hit
);

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_RUN_BP = 2'd3
  } state_e;

  localparam logic [3:0] OP_PAUSE   = 4'd1;
  localparam logic [3:0] OP_RUN     = 4'd2;
  localparam logic [3:0] OP_STEP    = 4'd3;
  localparam logic [3:0] OP_FLAGS   = 4'd4;
  localparam logic [3:0] OP_BP_VAL  = 4'd5;
  localparam logic [3:0] OP_BP_MASK = 4'd6;
  localparam logic [3:0] OP_RUN_BP  = 4'd7;

  state_e                state_q, state_d;
  logic [27:0]           step_q, step_d;
  logic [31:0]           flit_q, flit_d;
  logic [DEST_WIDTH-1:0] bp_val_q, bp_val_d;
  logic [DEST_WIDTH-1:0] bp_mask_q, bp_mask_d;
  logic                  pause_q, pause_d;
  logic                  drop_q, drop_d;
  logic                  log_q, log_d;
  logic                  hit_q, hit_d;

  logic                  xfer_s;
  logic                  bp_match_s;
  logic [3:0]            op_s;
  logic [27:0]           arg_s;

  // Ready is purely a function of reset; there is no backpressure on commands.
  assign cmd_TREADY = ~rst;

  assign xfer_s     = mon_TVALID & mon_TREADY;
  assign bp_match_s = ((mon_TDEST & bp_mask_q) == (bp_val_q & bp_mask_q));
  assign op_s       = cmd_TDATA[31:28];
  assign arg_s      = cmd_TDATA[27:0];

  // Next-state computation: xfer-driven progress first, then commands override.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    flit_d    = flit_q + {31'd0, xfer_s};
    bp_val_d  = bp_val_q;
    bp_mask_d = bp_mask_q;
    drop_d    = drop_q;
    log_d     = log_q;
    hit_d     = 1'b0;

    // Handshake progress is judged under the current state.
    case (state_q)
      ST_STEP: begin
        if (xfer_s) begin
          // Counter is always >= 1 here, so the decrement cannot underflow.
          step_d = step_q - 28'd1;
          if (step_q == 28'd1) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_STEP;
          end
        end else begin
          state_d = ST_STEP;
        end
      end
      ST_RUN_BP: begin
        // The matching flit itself passes; the stop takes effect after it.
        if (xfer_s && bp_match_s) begin
          state_d = ST_PAUSED;
          hit_d   = 1'b1;
        end else begin
          state_d = ST_RUN_BP;
        end
      end
      ST_RUN:    state_d = ST_RUN;
      ST_PAUSED: state_d = ST_PAUSED;
      default:   state_d = ST_PAUSED;
    endcase

    // An accepted command takes priority over the xfer-driven next state.
    if (cmd_TVALID) begin
      case (op_s)
        OP_PAUSE:  state_d = ST_PAUSED;
        OP_RUN:    state_d = ST_RUN;
        OP_STEP: begin
          step_d = arg_s;
          if (arg_s == 28'd0) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_STEP;
          end
        end
        OP_FLAGS: begin
          drop_d = arg_s[0];
          log_d  = arg_s[1];
        end
        OP_BP_VAL:  bp_val_d  = cmd_TDATA[DEST_WIDTH-1:0];
        OP_BP_MASK: bp_mask_d = cmd_TDATA[DEST_WIDTH-1:0];
        OP_RUN_BP:  state_d   = ST_RUN_BP;
        default:    state_d   = state_d;  // NOP and reserved opcodes
      endcase
    end else begin
      state_d = state_d;
    end

    // Pausing from the next state keeps the stop latency to one cycle.
    pause_d = (state_d == ST_PAUSED);
  end

  // Control state and registered governor outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_PAUSED;
      step_q    <= 28'd0;
      flit_q    <= 32'd0;
      bp_val_q  <= '0;
      bp_mask_q <= '0;
      pause_q   <= 1'b1;
      drop_q    <= 1'b0;
      log_q     <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      flit_q    <= flit_d;
      bp_val_q  <= bp_val_d;
      bp_mask_q <= bp_mask_d;
      pause_q   <= pause_d;
      drop_q    <= drop_d;
      log_q     <= log_d;
      hit_q     <= hit_d;
    end
  end

  assign pause      = pause_q;
  assign drop       = drop_q;
  assign log_en     = log_q;
  assign state      = state_q;
  assign flit_count = flit_q;
  assign bp_hit     = hit_q;

endmodule
